// File: rtl/multi_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// state encodings, opcode constants, mux-select constants and the
// packed control-output vector. Optional addi support is enabled by
// defining MULTI_CTRL_ADDI_EN, which adds states IEX (10) and IWB (11).
package multi_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IF  = 4'd0,
    ST_ID  = 4'd1,
    ST_MA  = 4'd2,
    ST_MR  = 4'd3,
    ST_MWB = 4'd4,
    ST_MW  = 4'd5,
    ST_REX = 4'd6,
    ST_RWB = 4'd7,
    ST_BEQ = 4'd8,
    ST_J   = 4'd9
`ifdef MULTI_CTRL_ADDI_EN
    ,
    ST_IEX = 4'd10,
    ST_IWB = 4'd11
`endif
  } state_t;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALUop codes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control output vector; field order matches the top-level unpacking.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_out_decode.sv
// Purely combinational Moore decode of the control FSM state into the
// datapath control vector. The only input-dependent outputs are the IF
// strobes IRWrite/PCWrite, which follow mem_ready. While reset is high
// every control output and the debug state are forced to zero.
// With MULTI_CTRL_ADDI_EN undefined, encodings 10 and 11 decode as unused.
module ctrl_out_decode
  import multi_ctrl_pkg::*;
(
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        dbg_state
);

  ctrl_t c;

  // Per-state output decode; unlisted outputs stay 0 via the default.
  always_comb begin
    c = '0;
    if (!reset) begin
      case (state)
        ST_IF: begin
          c.mem_read  = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          c.alu_op    = ALUOP_ADD;
          c.pc_source = PCSRC_ALU;
          c.ir_write  = mem_ready;
          c.pc_write  = mem_ready;
        end
        ST_ID: begin
          c.alu_src_b = SRCB_IMM_SH;
          c.alu_op    = ALUOP_ADD;
        end
        ST_MA: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALUOP_ADD;
        end
        ST_MR: begin
          c.mem_read = 1'b1;
          c.i_or_d   = 1'b1;
        end
        ST_MWB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        ST_MW: begin
          c.mem_write = 1'b1;
          c.i_or_d    = 1'b1;
        end
        ST_REX: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = ALUOP_FUNCT;
        end
        ST_RWB: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
        end
        ST_BEQ: begin
          c.alu_src_a     = 1'b1;
          c.alu_src_b     = SRCB_REG;
          c.alu_op        = ALUOP_SUB;
          c.pc_write_cond = 1'b1;
          c.pc_source     = PCSRC_ALUOUT;
        end
        ST_J: begin
          c.pc_write  = 1'b1;
          c.pc_source = PCSRC_JUMP;
        end
`ifdef MULTI_CTRL_ADDI_EN
        ST_IEX: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALUOP_ADD;
        end
        ST_IWB: begin
          c.reg_write = 1'b1;
        end
`endif
        default: c = '0;
      endcase
    end
  end

  assign ctrl      = c;
  assign dbg_state = reset ? 4'd0 : state;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// next-state logic; output decode lives in ctrl_out_decode.
// Optional addi support: define MULTI_CTRL_ADDI_EN.
//
// Memory handshake: MemRead/MemWrite are held for as long as the FSM sits
// in IF, MR or MW; mem_ready=1 in a cycle means the access completed in
// that cycle, and the FSM advances at the following rising edge. mem_ready
// is ignored in every other state.
module multi_cycle_ctrl
  import multi_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  state_t            state_q;
  state_t            state_d;
  logic [CTRL_W-1:0] ctrl;

  // State register with synchronous reset to IF.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  // Next-state logic; Op is only looked at in ID and MA.
  always_comb begin
    state_d = ST_IF;
    case (state_q)
      ST_IF:  state_d = mem_ready ? ST_ID : ST_IF;
      ST_ID: begin
        case (Op)
          OP_R:    state_d = ST_REX;
          OP_LW,
          OP_SW:   state_d = ST_MA;
          OP_BEQ:  state_d = ST_BEQ;
          OP_J:    state_d = ST_J;
`ifdef MULTI_CTRL_ADDI_EN
          OP_ADDI: state_d = ST_IEX;
`endif
          default: state_d = ST_IF;
        endcase
      end
      ST_MA: begin
        if      (Op == OP_LW) state_d = ST_MR;
        else if (Op == OP_SW) state_d = ST_MW;
        else                  state_d = ST_IF;
      end
      ST_MR:  state_d = mem_ready ? ST_MWB : ST_MR;
      ST_MWB: state_d = ST_IF;
      ST_MW:  state_d = mem_ready ? ST_IF : ST_MW;
      ST_REX: state_d = ST_RWB;
      ST_RWB: state_d = ST_IF;
      ST_BEQ: state_d = ST_IF;
      ST_J:   state_d = ST_IF;
`ifdef MULTI_CTRL_ADDI_EN
      ST_IEX: state_d = ST_IWB;
      ST_IWB: state_d = ST_IF;
`endif
      default: state_d = ST_IF;
    endcase
  end

  ctrl_out_decode u_decode (
    .reset     (reset),
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl),
    .dbg_state (state)
  );

  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource} = ctrl;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl: walks R-type, lw with memory
// stalls, sw, beq, j with an IF stall, illegal/addi opcodes and a reset
// abort in MW, checking state and the full control vector each cycle.
module tb_multi_cycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] state;
  logic [15:0] outs;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .Op          (Op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .PCSource    (PCSource),
    .state       (state)
  );

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build an expected control vector from hand-written field values.
  function automatic logic [15:0] mk(
    input logic pcw, input logic pcwc, input logic iord, input logic mrd,
    input logic mwr, input logic irw, input logic m2r, input logic rdst,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] pcs);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  // Expected vectors per state (hand-derived from the control table)
  logic [15:0] e_zero, e_if1, e_if0, e_id, e_ma, e_mr, e_mwb, e_mw;
  logic [15:0] e_rex, e_rwb, e_beq, e_j, e_iex, e_iwb;

  initial begin
    e_zero = 16'h0000;
    e_if1  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
    e_if0  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
    e_id   = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    e_ma   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    e_mr   = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    e_mwb  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    e_mw   = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    e_rex  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
    e_rwb  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    e_beq  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    e_j    = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
    e_iex  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    e_iwb  = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare state and full control vector; inputs are settled by #1.
  task automatic chk(input string tag, input logic [3:0] exp_state,
                     input logic [15:0] exp_outs);
    #1;
    checks++;
    assert (state === exp_state) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_state);
    end
    checks++;
    assert (outs === exp_outs) else begin
      errors++;
      $error("FAIL %s outs observed=%h expected=%h", tag, outs, exp_outs);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    reset = 1'b1; Op = 6'b000000; mem_ready = 1'b1;
    #1;
    // Reset held for three edges; everything must read zero throughout.
    chk("rst0", 4'd0, e_zero);
    cyc(); chk("rst1", 4'd0, e_zero);
    cyc(); chk("rst2", 4'd0, e_zero);
    cyc(); chk("rst3", 4'd0, e_zero);

    // R-type: 0,1,6,7,0. Op changes in REX must not matter.
    reset = 1'b0;
    chk("r_if", 4'd0, e_if1);
    cyc(); chk("r_id", 4'd1, e_id);
    cyc(); Op = 6'b100011; chk("r_rex", 4'd6, e_rex);
    cyc(); chk("r_rwb", 4'd7, e_rwb);
    cyc(); chk("r_done", 4'd0, e_if1);

    // lw with two stall cycles in MR: 0,1,2,3,3,3,4,0
    Op = 6'b100011;
    cyc(); chk("lw_id", 4'd1, e_id);
    cyc(); mem_ready = 1'b0; chk("lw_ma", 4'd2, e_ma);
    cyc(); chk("lw_mr0", 4'd3, e_mr);
    cyc(); chk("lw_mr1", 4'd3, e_mr);
    cyc(); mem_ready = 1'b1; chk("lw_mr2", 4'd3, e_mr);
    cyc(); chk("lw_mwb", 4'd4, e_mwb);
    cyc(); chk("lw_done", 4'd0, e_if1);

    // sw: MemWrite in exactly one cycle
    Op = 6'b101011;
    cyc(); chk("sw_id", 4'd1, e_id);
    cyc(); chk("sw_ma", 4'd2, e_ma);
    cyc(); chk("sw_mw", 4'd5, e_mw);
    cyc(); chk("sw_done", 4'd0, e_if1);

    // beq
    Op = 6'b000100;
    cyc(); chk("beq_id", 4'd1, e_id);
    cyc(); chk("beq_ex", 4'd8, e_beq);
    cyc(); chk("beq_done", 4'd0, e_if1);

    // j with one IF stall cycle
    Op = 6'b000010; mem_ready = 1'b0;
    chk("j_if_stall", 4'd0, e_if0);
    cyc(); mem_ready = 1'b1; chk("j_if_go", 4'd0, e_if1);
    cyc(); chk("j_id", 4'd1, e_id);
    cyc(); chk("j_ex", 4'd9, e_j);
    cyc(); chk("j_done", 4'd0, e_if1);

    // Illegal opcode: 0,1,0
    Op = 6'b111111;
    cyc(); chk("ill_id", 4'd1, e_id);
    cyc(); chk("ill_done", 4'd0, e_if1);

    // addi: IEX/IWB when enabled, NOP path otherwise
    Op = 6'b001000;
    cyc(); chk("addi_id", 4'd1, e_id);
`ifdef MULTI_CTRL_ADDI_EN
    cyc(); chk("addi_iex", 4'd10, e_iex);
    cyc(); chk("addi_iwb", 4'd11, e_iwb);
`endif
    cyc(); chk("addi_done", 4'd0, e_if1);

    // Reset while stalled in MW aborts the store.
    Op = 6'b101011;
    cyc(); chk("rmw_id", 4'd1, e_id);
    cyc(); mem_ready = 1'b0; chk("rmw_ma", 4'd2, e_ma);
    cyc(); chk("rmw_mw0", 4'd5, e_mw);
    cyc(); chk("rmw_mw1", 4'd5, e_mw);
    reset = 1'b1;
    chk("rmw_rst_hi", 4'd0, e_zero);
    cyc(); reset = 1'b0; chk("rmw_after", 4'd0, e_if0);
    mem_ready = 1'b1;
    chk("rmw_if", 4'd0, e_if1);
    cyc(); chk("rmw_id2", 4'd1, e_id);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Unused-expected guard so both build variants reference every vector.
  initial begin
    #0;
    if (e_iex === 16'hxxxx && e_iwb === 16'hxxxx) $display("note: addi vectors unset");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control FSM of the multi-cycle MIPS datapath, directly upstream of the ALU control decoder. Decodes the 6-bit opcode of the instruction register, sequences fetch, decode, execute, memory and write-back cycles, and drives all datapath enables and multiplexer selects. Its 2-bit `ALUop` output feeds the ALU control decoder, which combines it with the funct field. The FSM stalls on a memory-ready handshake so that multi-cycle memories can be used.

## Interface
Parameters: none.
- `clk`  in  1  single system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `Op`  in  6  opcode field IR[31:26], valid from ID onward
- `mem_ready`  in  1  memory has completed the current read or write this cycle
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  PC load qualified by the ALU Zero flag
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  instruction register load
- `MemtoReg`  out  1  register write data select: 0 = ALUOut, 1 = MDR
- `RegDst`  out  1  destination register select: 0 = rt, 1 = rd
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = register A
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `ALUop`  out  2  00 = add, 01 = sub, 10 = decode funct field
- `PCSource`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `state`  out  4  current state, for debug display

## Operation
- State encoding: IF=0, ID=1, MA=2, MR=3, MWB=4, MW=5, REX=6, RWB=7, BEQ=8, J=9, IEX=10, IWB=11.
- Every output not listed for a state is 0.
- **IF:** `MemRead`=1, `ALUSrcB`=01, `ALUop`=00, `PCSource`=00. `IRWrite` and `PCWrite` equal `mem_ready`. Move to ID when `mem_ready`=1; otherwise stay in IF.
- **ID:** `ALUSrcB`=11, `ALUop`=00. Next state by opcode:
  - 000000 → REX
  - 100011 (lw) and 101011 (sw) → MA
  - 000100 (beq) → BEQ
  - 000010 (j) → J
  - 001000 (addi) → IEX, only when `ADDI_EN` is defined
  - any other opcode → IF; the instruction is treated as a NOP.
- **MA:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00. Go to MR for lw, MW for sw.
- **MR:** `MemRead`=1, `IorD`=1. Stay until `mem_ready`=1, then go to MWB.
- **MWB:** `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Go to IF.
- **MW:** `MemWrite`=1, `IorD`=1. Stay until `mem_ready`=1, then go to IF.
- **REX:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=10. Go to RWB.
- **RWB:** `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Go to IF.
- **BEQ:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=01, `PCWriteCond`=1, `PCSource`=01. Go to IF.
- **J:** `PCWrite`=1, `PCSource`=10. Go to IF.
- **IEX:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00. Go to IWB.
- **IWB:** `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Go to IF.
- `Op` is sampled only in ID and MA. Changes on `Op` in any other state have no effect.
- Unused encodings 12–15: outputs all 0; next state IF.

## Timing
- All outputs are Moore-decoded from `state`. The only exception is `IRWrite`/`PCWrite` in IF, which are gated combinationally by `mem_ready`.
- `reset`=1 at a clock edge puts the FSM in IF (`state`=0).
- While `reset` is high, all control outputs are forced to 0, including the IF strobes. `state` reads 0.
- Reset asserted mid-instruction (e.g. in MW while stalled) aborts the instruction at the next edge. No partial write strobe is issued after that edge.
- Cycle counts with `mem_ready` tied high:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
- Each low cycle of `mem_ready` in IF, MR or MW adds one cycle.
- `mem_ready` is ignored in all other states.

## Configuration
- `MULTI_CTRL_ADDI_EN` defined: opcode 001000 decodes to IEX → IWB (4 cycles, writes rt with rs + imm).
- Not defined:
  - states IEX and IWB do not exist;
  - opcode 001000 takes the illegal-opcode path (ID → IF);
  - encodings 10 and 11 behave as unused encodings.

## Structure
- Package `multi_ctrl_pkg` holds:
  - state encodings;
  - opcode constants (R, LW, SW, BEQ, J, ADDI);
  - `ALUop` constants (ADD=00, SUB=01, FUNCT=10);
  - `ALUSrcB` and `PCSource` select constants.
- One sub-module is natural: `ctrl_out_decode`. It is purely combinational, maps `state` plus `mem_ready` to the control output vector, and also performs the reset gating.
- The top level holds only the state register and the next-state logic.

## Test plan
- Reset held 3 cycles, then released with `Op`=000000 and `mem_ready`=1:
  - during reset all outputs = 0;
  - after release, `state` runs 0, 1, 6, 7, 0;
  - `ALUop`=10 in state 6; `RegWrite`=1 and `RegDst`=1 in state 7.
- lw (100011) with `mem_ready` low for 2 cycles in MR:
  - `state` runs 0, 1, 2, 3, 3, 3, 4, 0;
  - `IorD`=1 and `MemRead`=1 throughout state 3;
  - `MemtoReg`=1 in state 4.
- sw (101011), then beq (000100):
  - sw: `MemWrite`=1 for exactly one cycle;
  - beq: `ALUop`=01, `PCWriteCond`=1, `PCSource`=01 in state 8.
- j (000010) with `mem_ready` low for 1 cycle in IF:
  - `IRWrite` and `PCWrite` = 0 in the stall cycle and 1 in the following cycle;
  - `PCSource`=10 in state 9.
- Illegal opcode 111111: `state` runs 0, 1, 0 with no write strobe asserted. With `MULTI_CTRL_ADDI_EN` defined, opcode 001000 runs 0, 1, 10, 11, 0.
- `reset` asserted while stalled in state 5: the next `state` is 0 and `MemWrite` drops to 0 at that edge.
